// File: rtl/ntr_pkg.sv
// Shared types and defaults for the NTR response streaming path.
// The byte-lane helper maps an emission index onto a word lane for either byte order.
package ntr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } ntr_state_e;

    localparam logic [7:0] NTR_FILL_DEFAULT       = 8'hFF;
    localparam int         NTR_WORD_BYTES_DEFAULT = 4;

    function automatic int ntr_byte_lane(input int idx, input int wb, input bit msb_first);
        int lane;
        if (msb_first) begin
            lane = wb - 1 - idx;
        end else begin
            lane = idx;
        end
        return lane;
    endfunction

endpackage

// File: rtl/ntr_respond_stream_if.sv
// Host command, byte strobe and source-word handshake bundle of the response streamer.
// The slave modport is the streamer's view; master is the command/source side.
interface ntr_respond_stream_if
    import ntr_pkg::*;
#(
    parameter int WORD_BYTES = NTR_WORD_BYTES_DEFAULT,
    parameter int LEN_W      = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len_words;
    logic                    en;
    logic [7:0]              out;
    logic                    busy;
    logic                    done;
    logic                    word_req;
    logic [8*WORD_BYTES-1:0] word_data;
    logic                    word_valid;
    logic                    underrun;

    modport slave (
        input  start, len_words, en, word_data, word_valid,
        output out, busy, done, word_req, underrun
    );

    modport master (
        output start, len_words, en, word_data, word_valid,
        input  out, busy, done, word_req, underrun
    );
endinterface

// File: rtl/ntr_word_prefetch.sv
// Two-entry word buffer: shift register SR with byte index, plus prefetch register PB.
// A loaded word lands in SR whenever SR is (or becomes) empty on that edge, else in PB.
module ntr_word_prefetch
    import ntr_pkg::*;
#(
    parameter int WORD_BYTES = NTR_WORD_BYTES_DEFAULT,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [8*WORD_BYTES-1:0] word,
    input  logic                    pop,
    output logic                    sr_full,
    output logic                    pb_full,
    output logic                    last_byte,
    output logic [7:0]              byte_sel
);
    localparam int              IDX_W    = $clog2(WORD_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

    logic [8*WORD_BYTES-1:0] sr_r, sr_s;
    logic [8*WORD_BYTES-1:0] pb_r, pb_s;
    logic                    sr_full_r, sr_full_s;
    logic                    pb_full_r, pb_full_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    int                      lane_s;
    logic [7:0]              byte_sel_s;

    // Next buffer contents: drain/refill from PB first, then place the incoming word.
    always_comb begin
        sr_s      = sr_r;
        pb_s      = pb_r;
        sr_full_s = sr_full_r;
        pb_full_s = pb_full_r;
        idx_s     = idx_r;
        if (pop && sr_full_r) begin
            if (idx_r == IDX_LAST) begin
                idx_s = {IDX_W{1'b0}};
                if (pb_full_r) begin
                    sr_s      = pb_r;
                    sr_full_s = 1'b1;
                    pb_full_s = 1'b0;
                end else begin
                    sr_full_s = 1'b0;
                end
            end else begin
                idx_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_s = idx_r;
        end
        if (load) begin
            if (!sr_full_s) begin
                sr_s      = word;
                sr_full_s = 1'b1;
                idx_s     = {IDX_W{1'b0}};
            end else begin
                pb_s      = word;
                pb_full_s = 1'b1;
            end
        end else begin
            pb_s = pb_s;
        end
    end

    // Byte lane selection for the current index in the configured byte order.
    always_comb begin
        lane_s     = ntr_byte_lane(int'(idx_r), WORD_BYTES, MSB_FIRST);
        byte_sel_s = 8'h00;
        for (int k = 0; k < WORD_BYTES; k++) begin
            byte_sel_s = byte_sel_s | (sr_r[8*k +: 8] & {8{lane_s == k}});
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r      <= '0;
            pb_r      <= '0;
            sr_full_r <= 1'b0;
            pb_full_r <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
        end else begin
            sr_r      <= sr_s;
            pb_r      <= pb_s;
            sr_full_r <= sr_full_s;
            pb_full_r <= pb_full_s;
            idx_r     <= idx_s;
        end
    end

    assign sr_full   = sr_full_r;
    assign pb_full   = pb_full_r;
    assign last_byte = (idx_r == IDX_LAST);
    assign byte_sel  = byte_sel_s;

endmodule

// File: rtl/ntr_respond_stream.sv
// NTR cartridge response serializer: streams len_words source words out one byte per en strobe.
// Owns the transfer FSM, the length counters and the source request handshake.
module ntr_respond_stream
    import ntr_pkg::*;
#(
    parameter int         WORD_BYTES = NTR_WORD_BYTES_DEFAULT,
    parameter int         LEN_W      = 8,
    parameter bit         MSB_FIRST  = 1'b1,
    parameter logic [7:0] FILL_BYTE  = NTR_FILL_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    ntr_respond_stream_if.slave  bus
);
    ntr_state_e       state_r, state_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] fetched_r;
    logic [LEN_W-1:0] sent_r;
    logic [7:0]       out_r;
    logic             underrun_r;

    logic             word_req_s;
    logic             accept_s;
    logic             pop_s;
    logic             final_pop_s;
    logic             start_ok_s;
    logic             sr_full_s;
    logic             pb_full_s;
    logic             last_byte_s;
    logic [7:0]       byte_sel_s;

    assign start_ok_s  = (state_r == ST_IDLE) && bus.start;
    assign word_req_s  = (state_r == ST_STREAM) && (fetched_r < len_r) && !pb_full_s;
    assign accept_s    = word_req_s && bus.word_valid;
    assign pop_s       = bus.en && (state_r == ST_STREAM) && sr_full_s;
    assign final_pop_s = pop_s && last_byte_s && (sent_r == (len_r - LEN_W'(1)));

    ntr_word_prefetch #(
        .WORD_BYTES (WORD_BYTES),
        .MSB_FIRST  (MSB_FIRST)
    ) u_prefetch (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .word      (bus.word_data),
        .pop       (pop_s),
        .sr_full   (sr_full_s),
        .pb_full   (pb_full_s),
        .last_byte (last_byte_s),
        .byte_sel  (byte_sel_s)
    );

    // Transfer FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = (bus.len_words == {LEN_W{1'b0}}) ? ST_FINISH : ST_STREAM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (final_pop_s) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Transfer FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Length latch and word counters; both counters stop at len, so they cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r     <= {LEN_W{1'b0}};
            fetched_r <= {LEN_W{1'b0}};
            sent_r    <= {LEN_W{1'b0}};
        end else if (start_ok_s && (bus.len_words != {LEN_W{1'b0}})) begin
            len_r     <= bus.len_words;
            fetched_r <= {LEN_W{1'b0}};
            sent_r    <= {LEN_W{1'b0}};
        end else begin
            if (accept_s) begin
                fetched_r <= fetched_r + LEN_W'(1);
            end
            if (pop_s && last_byte_s) begin
                sent_r <= sent_r + LEN_W'(1);
            end
        end
    end

    // Output byte register and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r      <= FILL_BYTE;
            underrun_r <= 1'b0;
        end else begin
            if (bus.en) begin
                out_r <= pop_s ? byte_sel_s : FILL_BYTE;
            end
            if (start_ok_s) begin
                underrun_r <= 1'b0;
            end else if (bus.en && (state_r == ST_STREAM) && !sr_full_s) begin
                underrun_r <= 1'b1;
            end
        end
    end

    assign bus.out      = out_r;
    assign bus.busy     = (state_r != ST_IDLE);
    assign bus.done     = (state_r == ST_FINISH);
    assign bus.word_req = word_req_s;
    assign bus.underrun = underrun_r;

endmodule
